// File: rtl/rf_phoenix_scoreboard.sv
// rf_phoenix_scoreboard: issue interlock for rfPhoenix multicycle register writes (scalar and vector files).
// Define RFPHOENIX_SB_WB_BYPASS_EN to let a same-cycle writeback release a stall (0-cycle wb-to-issue).
module rf_phoenix_scoreboard #(
  parameter int NREGS   = 64,
  parameter int MAX_OUT = 8,
  localparam int RW     = $clog2(NREGS),
  localparam int CW     = $clog2(MAX_OUT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          dec_v_i,
  input  logic [RW-1:0] ra_i,
  input  logic [RW-1:0] rb_i,
  input  logic [RW-1:0] rc_i,
  input  logic          ta_i,
  input  logic          tb_i,
  input  logic          tc_i,
  input  logic          rc_used_i,
  input  logic [RW-1:0] rt_i,
  input  logic          tt_i,
  input  logic          rfwr_i,
  input  logic          vrfwr_i,
  input  logic          multicycle_i,
  input  logic          store_i,
  input  logic          flush_i,
  output logic          dec_rdy_o,
  output logic          issue_o,
  input  logic          wb_v_i,
  input  logic [RW-1:0] wb_rt_i,
  input  logic          wb_tt_i,
  output logic          busy_o,
  output logic [CW-1:0] outstanding_o
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

  logic [NREGS-1:0] spend_q, vpend_q;
  logic [NREGS-1:0] spend_eff, vpend_eff;
  logic [NREGS-1:0] spend_n, vpend_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             wr_any, src_haz, dst_haz, cap_full;
  logic             set_s, set_v, cnt_dec;

  // Scalar r0 is hardwired, so it can never be pending.
  function automatic logic pend(input logic [RW-1:0] r, input logic t,
                                input logic [NREGS-1:0] sp, input logic [NREGS-1:0] vp);
    return t ? vp[r] : (sp[r] && (r != '0));
  endfunction

  always_comb begin
    spend_eff = spend_q;
    vpend_eff = vpend_q;
`ifdef RFPHOENIX_SB_WB_BYPASS_EN
    if (wb_v_i) begin
      if (wb_tt_i) vpend_eff[wb_rt_i] = 1'b0;
      else         spend_eff[wb_rt_i] = 1'b0;
    end
`endif
  end

  assign wr_any = rfwr_i | vrfwr_i;

  assign src_haz = pend(ra_i, ta_i, spend_eff, vpend_eff)
                 | pend(rb_i, tb_i, spend_eff, vpend_eff)
                 | (rc_used_i && pend(rc_i, tc_i, spend_eff, vpend_eff))
                 | (store_i   && pend(rt_i, tt_i, spend_eff, vpend_eff));

  assign dst_haz = wr_any && pend(rt_i, tt_i, spend_eff, vpend_eff);

`ifdef RFPHOENIX_SB_WB_BYPASS_EN
  assign cap_full = multicycle_i && wr_any && (cnt_q == CNT_MAX) && !wb_v_i;
`else
  assign cap_full = multicycle_i && wr_any && (cnt_q == CNT_MAX);
`endif

  assign dec_rdy_o = !src_haz && !dst_haz && !cap_full;
  assign issue_o   = dec_v_i && dec_rdy_o && !flush_i;

  assign set_s   = issue_o && multicycle_i && rfwr_i && (rt_i != '0);
  assign set_v   = issue_o && multicycle_i && vrfwr_i;
  assign cnt_dec = wb_v_i && (cnt_q != '0);

  // Clear first, then set: a new producer issued in the wb cycle owns the register.
  always_comb begin
    spend_n = spend_q;
    vpend_n = vpend_q;
    if (wb_v_i) begin
      if (wb_tt_i) vpend_n[wb_rt_i] = 1'b0;
      else         spend_n[wb_rt_i] = 1'b0;
    end
    if (set_s) spend_n[rt_i] = 1'b1;
    if (set_v) vpend_n[rt_i] = 1'b1;
    spend_n[0] = 1'b0;
  end

  assign cnt_n = cnt_q + CW'(set_s) + CW'(set_v) - CW'(cnt_dec);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spend_q <= '0;
      vpend_q <= '0;
      cnt_q   <= '0;
    end else begin
      spend_q <= spend_n;
      vpend_q <= vpend_n;
      cnt_q   <= cnt_n;
    end
  end

  assign busy_o        = (cnt_q != '0);
  assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_rf_phoenix_scoreboard.sv
// Table-driven bench for rf_phoenix_scoreboard with an expected-result queue.
module tb_rf_phoenix_scoreboard;

`ifdef RFPHOENIX_SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i, dec_v_i, ta_i, tb_i, tc_i, rc_used_i, tt_i;
  logic [5:0] ra_i, rb_i, rc_i, rt_i, wb_rt_i;
  logic       rfwr_i, vrfwr_i, multicycle_i, store_i, flush_i;
  logic       wb_v_i, wb_tt_i;
  logic       dec_rdy_o, issue_o, busy_o;
  logic [3:0] outstanding_o;

  int checks = 0;
  int errors = 0;

  rf_phoenix_scoreboard dut (
    .clk_i(clk), .rst_i(rst_i), .dec_v_i(dec_v_i),
    .ra_i(ra_i), .rb_i(rb_i), .rc_i(rc_i),
    .ta_i(ta_i), .tb_i(tb_i), .tc_i(tc_i), .rc_used_i(rc_used_i),
    .rt_i(rt_i), .tt_i(tt_i), .rfwr_i(rfwr_i), .vrfwr_i(vrfwr_i),
    .multicycle_i(multicycle_i), .store_i(store_i), .flush_i(flush_i),
    .dec_rdy_o(dec_rdy_o), .issue_o(issue_o),
    .wb_v_i(wb_v_i), .wb_rt_i(wb_rt_i), .wb_tt_i(wb_tt_i),
    .busy_o(busy_o), .outstanding_o(outstanding_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] ra, rb, rc, rt;
    logic ta, tb, tc, rcu, tt, rfwr, vrfwr, mc, st;
  } op_t;

  typedef struct {
    string      name;
    op_t        op;
    logic       v, fl, rst, wbv;
    logic [5:0] wbrt;
    logic       wbtt;
    logic       rdy, iss;
    logic [3:0] out;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic op_t o_nop();
    op_t o;
    o.ra = '0; o.rb = '0; o.rc = '0; o.rt = '0;
    o.ta = 0; o.tb = 0; o.tc = 0; o.rcu = 0; o.tt = 0;
    o.rfwr = 0; o.vrfwr = 0; o.mc = 0; o.st = 0;
    return o;
  endfunction

  function automatic op_t o_add(input logic [5:0] ra, input logic [5:0] rb, input logic [5:0] rt);
    op_t o = o_nop();
    o.ra = ra; o.rb = rb; o.rt = rt; o.rfwr = 1;
    return o;
  endfunction

  function automatic op_t o_ld(input logic [5:0] rt, input logic tt);
    op_t o = o_nop();
    o.rt = rt; o.tt = tt; o.mc = 1; o.rfwr = !tt; o.vrfwr = tt;
    return o;
  endfunction

  function automatic op_t o_fmav(input logic [5:0] ra, input logic [5:0] rb,
                                 input logic [5:0] rc, input logic [5:0] rt);
    op_t o = o_nop();
    o.ra = ra; o.rb = rb; o.rc = rc; o.rt = rt;
    o.ta = 1; o.tb = 1; o.tc = 1; o.rcu = 1; o.tt = 1; o.vrfwr = 1; o.mc = 1;
    return o;
  endfunction

  function automatic op_t o_st(input logic [5:0] rt, input logic tt);
    op_t o = o_nop();
    o.rt = rt; o.tt = tt; o.st = 1;
    return o;
  endfunction

  function automatic op_t o_rc(input logic [5:0] rc, input logic tc, input logic rcu);
    op_t o = o_nop();
    o.rc = rc; o.tc = tc; o.rcu = rcu; o.rt = 6'd20; o.rfwr = 1;
    return o;
  endfunction

  task automatic av(input string name, input op_t op, input logic v, input logic fl,
                    input logic rst, input logic wbv, input logic [5:0] wbrt, input logic wbtt,
                    input logic rdy, input logic iss, input logic [3:0] out);
    vec_t t;
    t.name = name; t.op = op; t.v = v; t.fl = fl; t.rst = rst;
    t.wbv = wbv; t.wbrt = wbrt; t.wbtt = wbtt;
    t.rdy = rdy; t.iss = iss; t.out = out;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input string what, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, what, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    dec_v_i = t.v; flush_i = t.fl; rst_i = t.rst;
    ra_i = t.op.ra; rb_i = t.op.rb; rc_i = t.op.rc; rt_i = t.op.rt;
    ta_i = t.op.ta; tb_i = t.op.tb; tc_i = t.op.tc; rc_used_i = t.op.rcu; tt_i = t.op.tt;
    rfwr_i = t.op.rfwr; vrfwr_i = t.op.vrfwr; multicycle_i = t.op.mc; store_i = t.op.st;
    wb_v_i = t.wbv; wb_rt_i = t.wbrt; wb_tt_i = t.wbtt;
  endtask

  task automatic apply(input vec_t t);
    logic a_rdy, a_iss;
    vec_t e;
    @(negedge clk);
    drive(t);
    exp_q.push_back(t);
    #1;
    a_rdy = dec_rdy_o;
    a_iss = issue_o;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(e.name, "dec_rdy", {7'd0, a_rdy}, {7'd0, e.rdy});
    chk(e.name, "issue", {7'd0, a_iss}, {7'd0, e.iss});
    chk(e.name, "outstanding", {4'd0, outstanding_o}, {4'd0, e.out});
    chk(e.name, "busy", {7'd0, busy_o}, {7'd0, (e.out != 0)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle;
    int first_iss;
    idle.name = "idle"; idle.op = o_nop(); idle.v = 0; idle.fl = 0; idle.rst = 1;
    idle.wbv = 0; idle.wbrt = '0; idle.wbtt = 0; idle.rdy = 1; idle.iss = 0; idle.out = 0;
    drive(idle);
    repeat (2) @(posedge clk);

    //    name            op                       v fl rs wbv wbrt wbtt rdy iss out
    av("reset_idle",     o_nop(),                  0, 0, 0, 0, 0, 0, 1, 0, 0);
    av("add_single",     o_add(1, 2, 3),           1, 0, 0, 0, 0, 0, 1, 1, 0);
    av("ld_r5",          o_ld(5, 0),               1, 0, 0, 0, 0, 0, 1, 1, 1);
    av("add_raw_r5",     o_add(5, 0, 6),           1, 0, 0, 0, 0, 0, 0, 0, 1);
    av("add_raw_r5_wb",  o_add(5, 0, 6),           1, 0, 0, 1, 5, 0, BYP, BYP, 0);
    av("add_after_wb",   o_add(5, 0, 6),           1, 0, 0, 0, 0, 0, 1, 1, 0);
    av("fma_v7",         o_fmav(1, 2, 3, 7),       1, 0, 0, 0, 0, 0, 1, 1, 1);
    av("add_reads_r7",   o_add(7, 7, 8),           1, 0, 0, 0, 0, 0, 1, 1, 1);
    av("rc_v7_unused",   o_rc(7, 1, 0),            1, 0, 0, 0, 0, 0, 1, 1, 1);
    av("rc_v7_used",     o_rc(7, 1, 1),            1, 0, 0, 0, 0, 0, 0, 0, 1);
    av("stt_v7",         o_st(7, 1),               1, 0, 0, 0, 0, 0, 0, 0, 1);
    av("stt_v7_wb",      o_st(7, 1),               1, 0, 0, 1, 7, 1, BYP, BYP, 0);
    av("stt_after",      o_st(7, 1),               1, 0, 0, 0, 0, 0, 1, 1, 0);
    av("flush_ld_r9",    o_ld(9, 0),               1, 1, 0, 0, 0, 0, 1, 0, 0);
    av("add_r9_flushed", o_add(9, 0, 10),          1, 0, 0, 0, 0, 0, 1, 1, 0);
    av("wb_underflow",   o_nop(),                  0, 0, 0, 1, 9, 0, 1, 0, 0);
    av("ld_r0",          o_ld(0, 0),               1, 0, 0, 0, 0, 0, 1, 1, 0);
    av("add_reads_r0",   o_add(0, 0, 11),          1, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 8; i++)
      av($sformatf("cap_ld_r%0d", i), o_ld(6'(i), 0), 1, 0, 0, 0, 0, 0, 1, 1, 4'(i));
    av("cap_ld_r9_full", o_ld(9, 0),               1, 0, 0, 0, 0, 0, 0, 0, 8);
    av("cap_ld_r9_wb",   o_ld(9, 0),               1, 0, 0, 1, 1, 0, BYP, BYP, BYP ? 4'd8 : 4'd7);
    av("cap_ld_r9_next", o_ld(9, 0),               1, 0, 0, 0, 0, 0, !BYP, !BYP, 8);
    for (int i = 2; i <= 9; i++)
      av($sformatf("drain_r%0d", i), o_nop(), 0, 0, 0, 1, 6'(i), 0, 1, 0, 4'(9 - i));
    av("sw_ld_r6",       o_ld(6, 0),               1, 0, 0, 0, 0, 0, 1, 1, 1);
    av("sw_ld_r4_wb_r4", o_ld(4, 0),               1, 0, 0, 1, 4, 0, 1, 1, 1);
    av("sw_add_r4",      o_add(4, 0, 7),           1, 0, 0, 0, 0, 0, 0, 0, 1);
    av("sw_wb_r4",       o_nop(),                  0, 0, 0, 1, 4, 0, 1, 0, 0);
    av("sw_add_r4_ok",   o_add(4, 0, 7),           1, 0, 0, 0, 0, 0, 1, 1, 0);
    av("sw_wb_r6_uf",    o_nop(),                  0, 0, 0, 1, 6, 0, 1, 0, 0);
    av("sw_add_r6_ok",   o_add(6, 0, 7),           1, 0, 0, 0, 0, 0, 1, 1, 0);
    av("waw_ld_r4",      o_ld(4, 0),               1, 0, 0, 0, 0, 0, 1, 1, 1);
    av("waw_ld_r4_wb",   o_ld(4, 0),               1, 0, 0, 1, 4, 0, BYP, BYP, BYP ? 4'd1 : 4'd0);
    av("waw_ld_r4_next", o_ld(4, 0),               1, 0, 0, 0, 0, 0, !BYP, !BYP, 1);
    av("rst_ld_r10",     o_ld(10, 0),              1, 0, 0, 0, 0, 0, 1, 1, 2);
    av("rst_ld_r11",     o_ld(11, 0),              1, 0, 0, 0, 0, 0, 1, 1, 3);
    av("rst_mid",        o_nop(),                  0, 0, 1, 0, 0, 0, 1, 0, 0);
    av("rst_wb_r10",     o_nop(),                  0, 0, 0, 1, 10, 0, 1, 0, 0);
    av("rst_add_r10",    o_add(10, 0, 12),         1, 0, 0, 0, 0, 0, 1, 1, 0);
    av("rst_add_r4",     o_add(4, 0, 12),          1, 0, 0, 0, 0, 0, 1, 1, 0);
    av("lat_ld_r12",     o_ld(12, 0),              1, 0, 0, 0, 0, 0, 1, 1, 1);

    foreach (vecs[i]) apply(vecs[i]);

    // Writeback of r12 arrives on cycle 2; measure which cycle the dependent ADD issues.
    first_iss = -1;
    for (int c = 0; c < 10 && first_iss < 0; c++) begin
      @(negedge clk);
      idle.name = "lat"; idle.op = o_add(12, 0, 13); idle.v = 1; idle.rst = 0;
      idle.wbv = (c == 2); idle.wbrt = 6'd12; idle.wbtt = 0;
      drive(idle);
      #1;
      if (issue_o) first_iss = c;
      @(posedge clk);
    end
    #1;
    if (first_iss < 0) begin
      checks++;
      errors++;
      $display("FAIL lat.issue_cycle: got none within 10 cycles expected %0d", BYP ? 2 : 3);
    end else begin
      chk("lat", "issue_cycle", 8'(first_iss), BYP ? 8'd2 : 8'd3);
    end
    chk("lat", "outstanding", {4'd0, outstanding_o}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_phoenix_scoreboard.md
Name: rf_phoenix_scoreboard

Overview:
- Issue-interlock scoreboard that consumes the decode bus from the rfPhoenix instruction decoder (the receiving end of that bus) and holds an instruction at issue until its operands and destination are hazard-free.
- Tracks pending writes of multicycle ops (FMA family, loads) separately in the scalar and vector register files.
- Clears pending state from the writeback port.
- Sits between decode and the execute/memory units.

Parameters:
- NREGS, 64, registers per file; register numbers are 6 bits (log2 NREGS).
- MAX_OUT, 8, maximum outstanding multicycle register writes.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- dec_v_i  in  1  decode bus valid
- ra_i, rb_i, rc_i  in  6 each  source register numbers
- ta_i, tb_i, tc_i  in  1 each  source is vector (1) / scalar (0)
- rc_used_i  in  1  Rc is a real source (FMA family)
- rt_i  in  6  destination, or store-data register for stores
- tt_i  in  1  Rt is vector
- rfwr_i, vrfwr_i  in  1 each  scalar / vector register write
- multicycle_i  in  1  op completes via writeback port
- store_i  in  1  Rt is a source (store data), not a destination
- flush_i  in  1  cancel the instruction presented this cycle
- dec_rdy_o  out  1  scoreboard can accept the presented instruction
- issue_o  out  1  instruction issued this cycle
- wb_v_i  in  1  multicycle writeback valid
- wb_rt_i  in  6  writeback register
- wb_tt_i  in  1  writeback is vector
- busy_o  out  1  one or more outstanding multicycle writes
- outstanding_o  out  4  outstanding count (width clog2(MAX_OUT+1))

Behaviour:
- State:
  - spend_q[NREGS-1:0]: scalar pending bits.
  - vpend_q[NREGS-1:0]: vector pending bits.
  - cnt_q: outstanding counter.
  - Reset: all zero, so busy_o=0, outstanding_o=0, dec_rdy_o=1 (when no hazard).
- Source hazard for (r,t): pending(r,t) = t ? vpend_q[r] : spend_q[r]. Scalar r0 is never pending.
- Sources checked:
  - Ra and Rb always.
  - Rc only if rc_used_i.
  - Rt (with tt_i) if store_i.
- Destination hazard (WAW): pending(rt_i,tt_i) when (rfwr_i|vrfwr_i).
- Capacity stall: multicycle_i && (rfwr_i|vrfwr_i) && cnt_q==MAX_OUT.
- dec_rdy_o = no source hazard && no destination hazard && no capacity stall. It is computed combinationally from registered state (plus bypass if enabled).
- issue_o = dec_v_i && dec_rdy_o && !flush_i.
- On issue_o with multicycle_i && rfwr_i && rt_i!=0:
  - set spend_q[rt_i] next cycle;
  - cnt_q+1.
- On issue_o with multicycle_i && vrfwr_i:
  - set vpend_q[rt_i] next cycle;
  - cnt_q+1.
- Single-cycle writers are not tracked; the forwarding network covers them.
- On wb_v_i: clear the pending bit for (wb_rt_i, wb_tt_i) next cycle and decrement cnt_q.
  - wb_v_i with cnt_q==0 is ignored for the counter (no underflow).
  - Scalar wb to r0 decrements cnt_q only.
- Simultaneous set and clear of the same register: set wins, since the new producer is now the owner. cnt_q nets to unchanged.
- Simultaneous issue and writeback of different registers: both apply; cnt_q unchanged.
- Without the optional feature, a hazard cleared by wb_v_i this cycle still stalls this cycle. Issue is possible on the following cycle (1-cycle wb-to-issue latency).
- flush_i suppresses issue_o and state updates for the presented instruction only. Pending bits and cnt_q are untouched, because in-flight ops still write back.
- rst_i mid-operation clears all pending bits and the counter. Later wb_v_i for pre-reset ops hits the underflow guard.
- busy_o = cnt_q!=0; outstanding_o = cnt_q.

Optional Feature:
- Macro: RFPHOENIX_SB_WB_BYPASS_EN.
- Defined: a pending bit cleared by a same-cycle wb_v_i (matching register and file) is treated as not pending when computing dec_rdy_o, giving 0-cycle wb-to-issue. A capacity stall is likewise relieved by a same-cycle wb_v_i.
- Not defined: the behaviour is exactly as above, with 1-cycle wb-to-issue latency.

Test Plan:
- Reset, then present ADD r3,r1,r2 (rfwr, single-cycle) -> dec_rdy_o=1, issue_o=1, spend_q stays 0, outstanding_o=0.
- Issue LDT scalar r5 (multicycle); next cycle present ADD reading Ra=r5 -> dec_rdy_o=0 until wb_v_i(r5,scalar). Without bypass, issue comes one cycle after wb; with RFPHOENIX_SB_WB_BYPASS_EN, issue comes in the wb cycle.
- Issue vector FMA writing v7; then present scalar op reading r7 -> no stall. Then present STT with store data v7 -> stall until wb(v7,vector).
- Issue 8 multicycle loads to r1..r8 -> outstanding_o=8. 9th load to r9 -> dec_rdy_o=0. One wb -> 9th issues next cycle, count returns to 8.
- LDT r4 pending and wb(r4) in the same cycle as issue of another LDT r4 -> spend_q[4]=1 afterward, count unchanged.
- Present valid instruction with flush_i=1 -> issue_o=0, no pending change. Assert rst_i with 3 outstanding -> busy_o=0 next cycle; a subsequent wb_v_i leaves outstanding_o=0.
